load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-access stage directly downstream of the ALU: ALU res is the byte address, rs2 the store data.
//  Turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW into word-aligned bus transactions with byte strobes.
//  Aligns and sign/zero-extends load data, flags misaligned or illegal accesses, and holds the core
//  (busy) while a variable-latency memory answers.
// PARAMETERS
//  (none) fixed 32-bit address/data, 4 byte lanes
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  req_valid   in   1   access request from execute stage
//  req_ready   out  1   LSU can accept a request (high only in IDLE)
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr    in   32  byte address (ALU res)
//  req_wdata   in   32  store data (rs2)
//  resp_valid  out  1   one-cycle completion pulse
//  resp_rdata  out  32  extended load data (0 for stores/errors)
//  resp_err    out  1   misaligned or illegal funct3; valid with resp_valid
//  busy        out  1   request in flight (state != IDLE)
//  mem_req     out  1   bus request, held until mem_gnt
//  mem_we      out  1   bus write enable
//  mem_addr    out  32  {req_addr[31:2],2'b00}
//  mem_wstrb   out  4   byte-lane strobes (0000 for loads)
//  mem_wdata   out  32  lane-replicated store data
//  mem_gnt     in   1   bus accepted the request this cycle
//  mem_rvalid  in   1   load data valid; store ack not used
//  mem_rdata   in   32  raw word read
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except req_ready=1. Reset mid-access abandons it; no resp.
//  FSM states IDLE, REQ, WAIT, RESP. All outputs registered.
//  IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata.
//   - error -> RESP with resp_err=1; no bus activity
//   - else -> REQ
//  Errors:
//   - funct3 not in {000,001,010,100,101} for loads
//   - funct3 not in {000,001,010} for stores
//   - H/HU with addr[0]=1
//   - W with addr[1:0]!=0
//  REQ: mem_req=1 with stable addr/we/wstrb/wdata until mem_gnt sampled high; bus outputs drop the
//   cycle after gnt. Exit on gnt: store -> RESP, load -> WAIT.
//  WAIT: ignore gnt; on mem_rvalid capture extracted data -> RESP. No timeout; waits indefinitely.
//  RESP: resp_valid=1 for exactly one cycle -> IDLE. resp_rdata holds until the next resp.
//  Store lanes (o=addr[1:0]):
//   - B: wdata={4{wdata[7:0]}},  wstrb=4'b0001<<o
//   - H: wdata={2{wdata[15:0]}}, wstrb=4'b0011<<o
//   - W: wdata as-is,            wstrb=4'b1111
//  Load extract: sh=mem_rdata>>(8*o). B/H sign-extend sh[7:0]/sh[15:0]; BU/HU zero-extend; W as-is.
//  mem_rvalid/mem_gnt outside REQ/WAIT: ignored. req_valid while busy: ignored; requester must hold it.
//  Latency: accept at edge N.
//   - store, gnt in first REQ cycle: resp_valid in cycle N+2
//   - load, rvalid one cycle after gnt: resp_valid in cycle N+3
//   - error: resp_valid in cycle N+1
// TESTING
//  1 SB addr=0x1003 wdata=0x000000AB, gnt immediate -> mem_addr=0x1000, wstrb=1000, wdata=0xABABABAB,
//    resp_valid at N+2, err=0
//  2 LB addr=0x2001, rdata=0x12F0_8034 -> resp_rdata=0xFFFFFF80;
//    LBU same -> 0x00000080; LHU addr=0x2002 -> 0x000012F0
//  3 LW addr=0x3002 -> resp_err=1, resp_valid at N+1, mem_req never asserted;
//    funct3=011 load -> err; SB funct3=100 -> err
//  4 gnt delayed 3 cycles, rvalid delayed 4 more -> mem_req stable 4 cycles, busy high throughout,
//    exactly one resp_valid pulse
//  5 rst asserted in WAIT, rvalid arrives next cycle -> no resp_valid, outputs 0, req_ready=1;
//    new LW completes normally
//  6 back-to-back: req_valid held high across two SW -> second accepted only in IDLE;
//    spurious rvalid in IDLE ignored

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit: sized accesses to a word-aligned strobed bus
//
// Sits after the ALU. A request's byte address comes from the ALU result and its
// store data from rs2. Each request becomes one word-aligned bus transaction with
// byte strobes. Load data is aligned and then sign- or zero-extended. A misaligned
// access or an illegal funct3 completes at once with resp_err and never touches the bus.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   req_valid/req_ready         request handshake; req_ready is high only in IDLE
//   req_we, req_funct3          1=store / 0=load; RISC-V access size and sign
//   req_addr, req_wdata         byte address, store data
//   resp_valid/rdata/err        one-cycle completion pulse, extended load data, error flag
//   busy                        an access is in flight
//   mem_req/we/addr/wstrb/wdata bus request, held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata  bus grant, read-data valid, raw read word

module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_we;

  logic        w_err;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_sh;
  logic [31:0] w_load;

  // Request legality. The unsigned variants have no store form.
  always_comb begin
    w_err = 1'b0;
    case (req_funct3)
      3'b000:  w_err = 1'b0;
      3'b001:  w_err = req_addr[0];
      3'b010:  w_err = |req_addr[1:0];
      3'b100:  w_err = req_we;
      3'b101:  w_err = req_we | req_addr[0];
      default: w_err = 1'b1;
    endcase
  end

  // Store data is replicated across every lane so that the strobes alone pick the target bytes.
  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << req_addr[1:0];
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
  end

  // Shift the addressed byte or halfword down to bit 0, then extend it.
  assign w_sh = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load = w_sh;
    case (r_funct3)
      3'b000:  w_load = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_load = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b100:  w_load = {24'h0, w_sh[7:0]};
      3'b101:  w_load = {16'h0, w_sh[15:0]};
      default: w_load = w_sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_funct3   <= 3'b000;
      r_off      <= 2'b00;
      r_we       <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wstrb  <= 4'h0;
      mem_wdata  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_funct3  <= req_funct3;
            r_off     <= req_addr[1:0];
            r_we      <= req_we;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (w_err) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              r_state   <= S_REQ;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wstrb <= req_we ? w_wstrb : 4'h0;
              mem_wdata <= req_we ? w_wdata : 32'h0;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wstrb <= 4'h0;
            mem_wdata <= 32'h0;
            if (r_we) begin
              // Stores are treated as complete once the bus accepts them.
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= 32'h0;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= w_load;
          end
        end
        S_RESP: begin
          // resp_rdata is left as it is and holds until the next completion.
          r_state    <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard testbench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   n_resp = 0;
  int   n_push = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response side of the scoreboard.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      n_resp++;
      if (sbq.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("resp_rdata", resp_rdata, mon_e.rdata);
        check("resp_err", 32'(resp_err), 32'(mon_e.err));
        check("resp_latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle. Returns at the negedge following acceptance.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic push, input logic e_err,
                      input logic [31:0] e_rdata, input int e_lat, input logic hold);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    if (push) begin
      sbq.push_back('{e_err, e_rdata, e_lat, cyc});
      n_push++;
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("ready_after_accept", 32'(req_ready), 32'd0);
  endtask

  // Bus side: grant after gd cycles; for loads, return data rd cycles after the earliest point.
  task automatic serve(input logic is_load, input int gd, input int rd, input logic [31:0] rdata,
                       input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_wstrb,
                       input logic [31:0] e_wdata);
    for (int i = 0; i <= gd; i++) begin
      check("mem_req", 32'(mem_req), 32'd1);
      check("mem_addr", mem_addr, e_addr);
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
      if (e_we) check("mem_wdata", mem_wdata, e_wdata);
      check("busy_req", 32'(busy), 32'd1);
      if (i == gd) mem_gnt = 1'b1;
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    check("mem_req_drop", 32'(mem_req), 32'd0);
    if (is_load) begin
      for (int i = 0; i < rd; i++) begin
        check("busy_wait", 32'(busy), 32'd1);
        @(negedge clk);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] o,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*o +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] o);
    if (f3[1:0] == 2'b00) begin
      case (o)
        2'd0:    return 4'b0001;
        2'd1:    return 4'b0010;
        2'd2:    return 4'b0100;
        default: return 4'b1000;
      endcase
    end else if (f3[1:0] == 2'b01) begin
      return o[1] ? 4'b1100 : 4'b0011;
    end
    return 4'b1111;
  endfunction

  logic        t_we;
  logic [2:0]  t_f3;
  logic [31:0] t_a;
  logic [31:0] t_wd;
  logic [31:0] t_rd;
  logic [31:0] t_ew;
  int          t_gd;
  int          t_rl;
  int          t_pulses;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Byte store to lane 3.
    send(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 1'b1, 1'b0, 32'h0, 2, 1'b0);
    serve(1'b0, 0, 0, 32'h0, 32'h0000_1000, 1'b1, 4'b1000, 32'hABAB_ABAB);
    idle(1);

    // Load extraction and extension.
    send(1'b0, 3'b000, 32'h0000_2001, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF80, 3, 1'b0);
    serve(1'b1, 0, 0, 32'h12F0_8034, 32'h0000_2000, 1'b0, 4'b0000, 32'h0);
    idle(1);
    send(1'b0, 3'b100, 32'h0000_2001, 32'h0, 1'b1, 1'b0, 32'h0000_0080, 3, 1'b0);
    serve(1'b1, 0, 0, 32'h12F0_8034, 32'h0000_2000, 1'b0, 4'b0000, 32'h0);
    idle(1);
    send(1'b0, 3'b001, 32'h0000_2002, 32'h0, 1'b1, 1'b0, 32'hFFFF_8001, 3, 1'b0);
    serve(1'b1, 0, 0, 32'h8001_0000, 32'h0000_2000, 1'b0, 4'b0000, 32'h0);
    idle(1);
    send(1'b0, 3'b101, 32'h0000_2002, 32'h0, 1'b1, 1'b0, 32'h0000_12F0, 3, 1'b0);
    serve(1'b1, 0, 0, 32'h12F0_8034, 32'h0000_2000, 1'b0, 4'b0000, 32'h0);
    idle(3);
    check("rdata_hold", resp_rdata, 32'h0000_12F0);

    // Halfword and word stores.
    send(1'b1, 3'b001, 32'h0000_4002, 32'hFFFF_1234, 1'b1, 1'b0, 32'h0, 2, 1'b0);
    serve(1'b0, 0, 0, 32'h0, 32'h0000_4000, 1'b1, 4'b1100, 32'h1234_1234);
    idle(1);
    send(1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 2, 1'b0);
    serve(1'b0, 0, 0, 32'h0, 32'h0000_4000, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    idle(1);

    // Errors complete in one cycle with no bus activity.
    send(1'b0, 3'b010, 32'h0000_3002, 32'h0, 1'b1, 1'b1, 32'h0, 1, 1'b0);
    check("err_no_mem_req", 32'(mem_req), 32'd0);
    idle(1);
    check("err_no_mem_req2", 32'(mem_req), 32'd0);
    send(1'b0, 3'b011, 32'h0000_3000, 32'h0, 1'b1, 1'b1, 32'h0, 1, 1'b0);
    idle(1);
    send(1'b1, 3'b100, 32'h0000_3000, 32'h55, 1'b1, 1'b1, 32'h0, 1, 1'b0);
    idle(1);
    send(1'b0, 3'b101, 32'h0000_3001, 32'h0, 1'b1, 1'b1, 32'h0, 1, 1'b0);
    check("err_no_mem_req3", 32'(mem_req), 32'd0);
    idle(1);

    // Slow grant and slow read data.
    t_pulses = n_resp;
    send(1'b0, 3'b010, 32'h0000_5000, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D, 10, 1'b0);
    serve(1'b1, 3, 4, 32'hCAFE_F00D, 32'h0000_5000, 1'b0, 4'b0000, 32'h0);
    idle(2);
    check("slow_one_pulse", 32'(n_resp - t_pulses), 32'd1);

    // Reset while waiting for read data abandons the access.
    send(1'b0, 3'b010, 32'h0000_5100, 32'h0, 1'b0, 1'b0, 32'h0, 0, 1'b0);
    check("rst_case_mem_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rst_case_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_resp_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("postrst_resp_valid", 32'(resp_valid), 32'd0);
    check("postrst_busy", 32'(busy), 32'd0);
    idle(1);
    send(1'b0, 3'b010, 32'h0000_6000, 32'h0, 1'b1, 1'b0, 32'h1122_3344, 3, 1'b0);
    serve(1'b1, 0, 0, 32'h1122_3344, 32'h0000_6000, 1'b0, 4'b0000, 32'h0);
    idle(1);

    // Back-to-back stores with req_valid held high.
    send(1'b1, 3'b010, 32'h0000_7000, 32'h0102_0304, 1'b1, 1'b0, 32'h0, 2, 1'b1);
    req_addr  = 32'h0000_7004;
    req_wdata = 32'h0506_0708;
    serve(1'b0, 0, 0, 32'h0, 32'h0000_7000, 1'b1, 4'b1111, 32'h0102_0304);
    @(negedge clk);
    check("b2b_ready_idle", 32'(req_ready), 32'd1);
    check("b2b_no_req_yet", 32'(mem_req), 32'd0);
    sbq.push_back('{1'b0, 32'h0, 2, cyc + 1});
    n_push++;
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    serve(1'b0, 0, 0, 32'h0, 32'h0000_7004, 1'b1, 4'b1111, 32'h0506_0708);
    idle(1);

    // Stray bus strobes in IDLE.
    mem_rvalid = 1'b1;
    mem_gnt    = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    check("spurious_busy", 32'(busy), 32'd0);
    check("spurious_ready", 32'(req_ready), 32'd1);
    check("spurious_mem_req", 32'(mem_req), 32'd0);
    idle(2);

    // Random aligned accesses with random bus timing.
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 4))
        0:       t_f3 = 3'b000;
        1:       t_f3 = 3'b001;
        2:       t_f3 = 3'b010;
        3:       t_f3 = 3'b100;
        default: t_f3 = 3'b101;
      endcase
      t_we = 1'($urandom_range(0, 1));
      if (t_we) t_f3[2] = 1'b0;
      t_a = $urandom;
      if (t_f3[1:0] == 2'b01) t_a[0] = 1'b0;
      if (t_f3[1:0] == 2'b10) t_a[1:0] = 2'b00;
      t_wd = $urandom;
      t_rd = $urandom;
      t_gd = $urandom_range(0, 2);
      t_rl = $urandom_range(0, 2);
      case (t_f3[1:0])
        2'b00:   t_ew = {4{t_wd[7:0]}};
        2'b01:   t_ew = {2{t_wd[15:0]}};
        default: t_ew = t_wd;
      endcase
      if (t_we) begin
        send(1'b1, t_f3, t_a, t_wd, 1'b1, 1'b0, 32'h0, 2 + t_gd, 1'b0);
        serve(1'b0, t_gd, 0, 32'h0, {t_a[31:2], 2'b00}, 1'b1, model_strb(t_f3, t_a[1:0]), t_ew);
      end else begin
        send(1'b0, t_f3, t_a, 32'h0, 1'b1, 1'b0, model_load(t_f3, t_a[1:0], t_rd),
             3 + t_gd + t_rl, 1'b0);
        serve(1'b1, t_gd, t_rl, t_rd, {t_a[31:2], 2'b00}, 1'b0, 4'b0000, 32'h0);
      end
      idle(1);
    end

    idle(3);
    check("resp_count", 32'(n_resp), 32'(n_push));
    check("queue_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
